// File: rtl/cpu_pkg.sv
// Shared register-file types for the RV32 pipeline control blocks.
// Holds the register address width, register count and the ID-stage issue request.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      use_rs1;
        logic      use_rs2;
        logic      reg_write;
        logic      long_op;
    } issue_req_t;

endpackage

// File: rtl/sb_popcount.sv
// Combinational population count of an N-bit vector.
// Sizes the pending-register count from the scoreboard bitmap.
module sb_popcount #(
    parameter int N = 32,
    parameter int W = 6
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] cnt
);

    // NOTE: the default before the loop keeps every path assigned, so no latch is inferred.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(vec[i]);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage pending-write scoreboard for long-latency producers (loads, mul/div).
// Stalls issue on RAW/WAW against in-flight long ops; writeback clears are visible the same cycle.
module reg_scoreboard #(
    parameter int NREG        = 32,
    parameter int STALL_LIMIT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_reg_write,
    input  logic            issue_long,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            issue_stall,
    output logic [NREG-1:0] busy_vec,
    output logic [5:0]      pending_cnt,
    output logic            stall_timeout,
    output logic            spurious_wb
);

    import cpu_pkg::*;

    localparam logic [6:0] LIMIT = 7'(STALL_LIMIT);

    issue_req_t      req;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] eff_busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] busy_next;
    logic [5:0]      cnt_next;
    logic [6:0]      stall_cnt;
    logic [6:0]      stall_cnt_next;
    logic            hazard;
    logic            fire;
    logic            wb_spurious;

    assign req = '{
        rs1:       issue_rs1,
        rs2:       issue_rs2,
        rd:        issue_rd,
        use_rs1:   issue_use_rs1,
        use_rs2:   issue_use_rs2,
        reg_write: issue_reg_write,
        long_op:   issue_long
    };

    always_comb begin
        wb_mask = '0;
        if (wb_valid && wb_rd != '0) begin
            wb_mask[wb_rd] = 1'b1;
        end

        // Write-through register file: a retiring producer no longer blocks its consumers.
        eff_busy = busy_vec & ~wb_mask;

        hazard = issue_valid && !flush &&
                 ((req.use_rs1   && req.rs1 != '0 && eff_busy[req.rs1]) ||
                  (req.use_rs2   && req.rs2 != '0 && eff_busy[req.rs2]) ||
                  (req.reg_write && req.rd  != '0 && eff_busy[req.rd]));
        fire   = issue_valid && !flush && !hazard;

        set_mask = '0;
        if (fire && req.reg_write && req.long_op && req.rd != '0) begin
            set_mask[req.rd] = 1'b1;
        end

        // Set is OR-ed after the clear so a new producer of the same register stays pending.
        busy_next    = eff_busy | set_mask;
        busy_next[0] = 1'b0;

        wb_spurious = wb_valid && wb_rd != '0 && !busy_vec[wb_rd];

        if (!hazard) begin
            stall_cnt_next = '0;
        end else if (stall_cnt >= LIMIT) begin
            stall_cnt_next = LIMIT;
        end else begin
            stall_cnt_next = stall_cnt + 7'd1;
        end
    end

    assign issue_stall = hazard;

    sb_popcount #(
        .N (NREG),
        .W (6)
    ) u_popcount (
        .vec (busy_next),
        .cnt (cnt_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_vec      <= '0;
            pending_cnt   <= '0;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
            spurious_wb   <= 1'b0;
        end else begin
            busy_vec      <= busy_next;
            pending_cnt   <= cnt_next;
            stall_cnt     <= stall_cnt_next;
            stall_timeout <= stall_timeout | (stall_cnt_next == LIMIT);
            spurious_wb   <= spurious_wb | wb_spurious;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a behavioural model pushes expected post-edge
// state into a queue each cycle, popped and compared once the DUT has clocked.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic        issue_long;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        issue_stall;
    logic [31:0] busy_vec;
    logic [5:0]  pending_cnt;
    logic        stall_timeout;
    logic        spurious_wb;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .NREG        (32),
        .STALL_LIMIT (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_use_rs1   (issue_use_rs1),
        .issue_use_rs2   (issue_use_rs2),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .issue_long      (issue_long),
        .flush           (flush),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .issue_stall     (issue_stall),
        .busy_vec        (busy_vec),
        .pending_cnt     (pending_cnt),
        .stall_timeout   (stall_timeout),
        .spurious_wb     (spurious_wb)
    );

    typedef struct {
        logic [31:0] busy;
        logic [5:0]  cnt;
        logic        timeout;
        logic        spur;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] m_busy;
    int          m_stall_cnt;
    logic        m_timeout;
    logic        m_spur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_busy      = '0;
        m_stall_cnt = 0;
        m_timeout   = 1'b0;
        m_spur      = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive, check the combinational stall, advance the model, check post-edge state.
    task automatic cycle(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic lng, input logic fl,
                         input logic wbv, input logic [4:0] wbrd);
        logic [31:0] eff;
        logic [31:0] nxt;
        logic        hz;
        logic        fire;
        exp_t        e;

        issue_valid     = v;
        issue_rs1       = rs1;
        issue_use_rs1   = u1;
        issue_rs2       = rs2;
        issue_use_rs2   = u2;
        issue_rd        = rd;
        issue_reg_write = rw;
        issue_long      = lng;
        flush           = fl;
        wb_valid        = wbv;
        wb_rd           = wbrd;
        #1;

        eff = m_busy;
        if (wbv) eff[wbrd] = 1'b0;
        hz = v && !fl && ((u1 && rs1 != 0 && eff[rs1]) ||
                          (u2 && rs2 != 0 && eff[rs2]) ||
                          (rw && rd  != 0 && eff[rd]));
        check("issue_stall", {31'b0, issue_stall}, {31'b0, hz});

        fire = v && !fl && !hz;
        nxt  = m_busy;
        if (wbv && wbrd != 0) begin
            if (!m_busy[wbrd]) m_spur = 1'b1;
            nxt[wbrd] = 1'b0;
        end
        if (fire && rw && lng && rd != 0) nxt[rd] = 1'b1;
        m_busy = nxt;
        if (hz) m_stall_cnt = (m_stall_cnt < 64) ? m_stall_cnt + 1 : 64;
        else    m_stall_cnt = 0;
        if (m_stall_cnt == 64) m_timeout = 1'b1;
        exp_q.push_back('{m_busy, 6'($countones(m_busy)), m_timeout, m_spur});

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("busy_vec",      busy_vec,                 e.busy);
        check("pending_cnt",   {26'b0, pending_cnt},     {26'b0, e.cnt});
        check("stall_timeout", {31'b0, stall_timeout},   {31'b0, e.timeout});
        check("spurious_wb",   {31'b0, spurious_wb},     {31'b0, e.spur});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fire_long(input logic [4:0] rd);
        cycle(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0);
    endtask

    task automatic writeback(input logic [4:0] rd);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        issue_valid     = 1'b0;
        issue_rs1       = '0;
        issue_rs2       = '0;
        issue_use_rs1   = 1'b0;
        issue_use_rs2   = 1'b0;
        issue_rd        = '0;
        issue_reg_write = 1'b0;
        issue_long      = 1'b0;
        flush           = 1'b0;
        wb_valid        = 1'b0;
        wb_rd           = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check("rst_busy_vec",      busy_vec,                 32'h0);
        check("rst_pending_cnt",   {26'b0, pending_cnt},     32'h0);
        check("rst_stall_timeout", {31'b0, stall_timeout},   32'h0);
        check("rst_spurious_wb",   {31'b0, spurious_wb},     32'h0);
        check("rst_issue_stall",   {31'b0, issue_stall},     32'h0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Load-use: x5 producer, dependent stalls until the writeback cycle.
        fire_long(5);
        check("lu_busy5_set", {31'b0, busy_vec[5]}, 32'h1);
        check("lu_cnt_one",   {26'b0, pending_cnt}, 32'h1);
        for (int i = 0; i < 3; i++) cycle(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        cycle(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 5);
        check("lu_busy5_clr", {31'b0, busy_vec[5]}, 32'h0);
        check("lu_cnt_zero",  {26'b0, pending_cnt}, 32'h0);

        // WAW on x7: short writer stalls, non-writer with same rd does not; rs2 RAW too.
        fire_long(7);
        cycle(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 2, 1, 7, 0, 0, 0, 0, 0);
        cycle(1, 3, 1, 7, 1, 8, 1, 0, 0, 0, 0);
        cycle(1, 3, 1, 7, 0, 8, 1, 0, 0, 0, 0);
        writeback(7);

        // x0 is never pending.
        fire_long(0);
        check("x0_busy_zero", busy_vec, 32'h0);
        cycle(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);

        // Same-cycle writeback and new producer of x9: set wins.
        fire_long(9);
        fire_long(20);
        cycle(1, 9, 1, 0, 0, 9, 1, 1, 0, 1, 9);
        check("sim_busy9", {31'b0, busy_vec[9]}, 32'h1);
        check("sim_cnt",   {26'b0, pending_cnt}, 32'h2);
        writeback(9);
        writeback(20);

        // Flush suppresses stall and set; spurious writeback is sticky.
        fire_long(3);
        cycle(1, 3, 1, 0, 0, 4, 1, 1, 1, 0, 0);
        check("fl_no_set4", {31'b0, busy_vec[4]}, 32'h0);
        writeback(3);
        writeback(12);
        check("spur_set",   {31'b0, spurious_wb}, 32'h1);
        check("spur_busy",  busy_vec, 32'h0);
        idle();

        // Reset mid-operation drops pending entries.
        fire_long(11);
        fire_long(13);
        do_reset();

        // Timeout: 64 consecutive stall cycles on x10.
        fire_long(10);
        for (int i = 0; i < 63; i++) cycle(1, 10, 1, 0, 0, 14, 1, 0, 0, 0, 0);
        check("to_not_yet", {31'b0, stall_timeout}, 32'h0);
        cycle(1, 10, 1, 0, 0, 14, 1, 0, 0, 0, 0);
        check("to_rise",    {31'b0, stall_timeout}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(1, 10, 1, 0, 0, 14, 1, 0, 0, 0, 0);
        cycle(1, 10, 1, 0, 0, 14, 1, 0, 0, 1, 10);
        idle();
        check("to_sticky",  {31'b0, stall_timeout}, 32'h1);

        // Random mix against the model.
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
